// File: rtl/pcileech_com_rx_pack_if.sv
// rtl/pcileech_com_rx_pack_if.sv - word/command handshake bundle for the COM receive packer
interface pcileech_com_rx_pack_if;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/pcileech_com_rx_pack.sv
// rtl/pcileech_com_rx_pack.sv - drops host filler words and pairs 32-bit words into 64-bit commands
module pcileech_com_rx_pack #(
    parameter logic [31:0] PARAM_FILLER  = 32'h66665555,
    parameter int          PARAM_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    pcileech_com_rx_pack_if.slave        bus,
    output logic [15:0]                  stat_filler,
    output logic [15:0]                  stat_timeout,
    output logic                         half_pending
);
    localparam int             CW      = $clog2(PARAM_TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'(PARAM_TIMEOUT - 1);

    typedef enum logic {
        S_EMPTY,
        S_HALF
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    lo_reg;
    logic [CW-1:0]  to_cnt;
    logic [63:0]    dout_q;
    logic           dout_valid_q;

    logic accept;
    logic is_filler;
    logic take_word;
    logic pair_done;
    logic timeout_hit;

    assign bus.din_ready  = ~dout_valid_q | bus.dout_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign half_pending   = (state_q == S_HALF);

    assign accept      = bus.din_valid & bus.din_ready;
    assign is_filler   = (bus.din == PARAM_FILLER);
    assign take_word   = accept & ~is_filler;
    assign pair_done   = take_word & (state_q == S_HALF);
    // A partner word arriving on the timeout cycle takes priority over the discard.
    assign timeout_hit = (state_q == S_HALF) & ~take_word & (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (take_word) state_d = S_HALF;
            S_HALF:  if (take_word || timeout_hit) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_reg       <= '0;
            to_cnt       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            stat_filler  <= '0;
            stat_timeout <= '0;
        end else begin
            if (take_word && state_q == S_EMPTY) begin
                lo_reg <= bus.din;
                to_cnt <= '0;
            end else if (state_q == S_HALF && !take_word) begin
                to_cnt <= timeout_hit ? '0 : to_cnt + 1'b1;
            end

            if (pair_done) begin
                dout_q       <= {bus.din, lo_reg};
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            if (accept && is_filler && stat_filler != 16'hFFFF) begin
                stat_filler <= stat_filler + 16'd1;
            end
            if (timeout_hit && stat_timeout != 16'hFFFF) begin
                stat_timeout <= stat_timeout + 16'd1;
            end
        end
    end
endmodule
